// File: rtl/debug_link_pkg.sv
// Shared constants and state encoding for the host debug link.
package debug_link_pkg;

    // Host opcodes
    localparam logic [7:0] OP_PROG = 8'h50;  // 'P': program code ROM
    localparam logic [7:0] OP_CMD  = 8'h43;  // 'C': issue debug command

    // Status bytes returned to the host
    localparam logic [7:0] RSP_OK  = 8'h4B;  // 'K'
    localparam logic [7:0] RSP_ERR = 8'h45;  // 'E'
    localparam logic [7:0] RSP_TMO = 8'h54;  // 'T'

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR_HI,
        S_ADDR_LO,
        S_LEN,
        S_DATA,
        S_ARG,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

endpackage

// File: rtl/debug_host_link.sv
// Byte-stream decoder between the host UART and the debug harness. Turns 'P' packets into
// code-ROM write strobes and 'C' packets into single-cycle debug commands, and answers every
// packet with one status byte.
module debug_host_link
    import debug_link_pkg::*;
#(
    parameter int unsigned ADDR_W         = 12,
    parameter int unsigned MAX_CMD        = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset_code_rom_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic              command_complete,
    output logic [3:0]        debug_cmd,
    output logic [7:0]        code_rom_data_in,
    output logic [ADDR_W-1:0] code_rom_addr_in,
    output logic              program_rom_mode,
    output logic              busy
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;

    state_e            state_q, state_d;
    logic [7:0]        hi_q, hi_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [8:0]        cnt_q, cnt_d;
    logic [3:0]        arg_q, arg_d;
    logic [7:0]        rsp_q, rsp_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              wr_q, wr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic              resp_show;

    // State and datapath registers; reset abandons any packet in flight.
    always_ff @(posedge clk or negedge reset_code_rom_n) begin
        if (!reset_code_rom_n) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            arg_q   <= '0;
            rsp_q   <= '0;
            tmo_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            waddr_q <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            arg_q   <= arg_d;
            rsp_q   <= rsp_d;
            tmo_q   <= tmo_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            waddr_q <= waddr_d;
        end
    end

    // Packet parser: next state, handshakes and harness outputs.
    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        arg_d     = arg_q;
        rsp_d     = rsp_q;
        tmo_d     = tmo_q;
        wr_d      = 1'b0;
        wdata_d   = wdata_q;
        waddr_d   = waddr_q;
        rx_ready  = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = '0;
        debug_cmd = '0;
        resp_show = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    if (rx_data == OP_PROG) begin
                        state_d = S_ADDR_HI;
                    end else if (rx_data == OP_CMD) begin
                        state_d = S_ARG;
                    end else begin
                        rsp_d   = RSP_ERR;
                        state_d = S_RESP;
                    end
                end
            end
            S_ADDR_HI: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    hi_d    = rx_data;
                    state_d = S_ADDR_LO;
                end
            end
            S_ADDR_LO: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    addr_d  = ADDR_W'({hi_q, rx_data});
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    // A zero count byte stands for a full 256-byte block
                    cnt_d   = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    wr_d    = 1'b1;
                    wdata_d = rx_data;
                    waddr_d = addr_q;
                    addr_d  = addr_q + ADDR_W'(1);
                    cnt_d   = cnt_q - 9'd1;
                    if (cnt_q == 9'd1) begin
                        rsp_d   = RSP_OK;
                        state_d = S_RESP;
                    end
                end
            end
            S_ARG: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    if (rx_data == 8'd0 || 32'(rx_data) > MAX_CMD) begin
                        rsp_d   = RSP_ERR;
                        state_d = S_RESP;
                    end else begin
                        arg_d   = rx_data[3:0];
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                debug_cmd = arg_q;
                tmo_d     = '0;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                tmo_d = tmo_q + TW'(1);
                // Completion takes priority over a timeout landing in the same cycle
                if (command_complete) begin
                    rsp_d   = RSP_OK;
                    state_d = S_RESP;
                end else if (tmo_d == TW'(TIMEOUT_CYCLES - 1)) begin
                    rsp_d   = RSP_TMO;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                // Hold the status back while the final ROM write strobe is still out
                resp_show = !wr_q;
                tx_valid  = resp_show;
                tx_data   = rsp_q;
                if (resp_show && tx_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign program_rom_mode = wr_q;
    assign code_rom_data_in = wdata_q;
    assign code_rom_addr_in = waddr_q;
    assign busy             = (state_q != S_IDLE);

endmodule

// File: tb/tb_debug_host_link.sv
// Self-checking bench for debug_host_link: directed vector table, hand-written corner cases
// and randomized packets against a packet-level reference model.
module tb_debug_host_link;

    localparam int unsigned ADDR_W  = 12;
    localparam int unsigned MAX_CMD = 3;
    localparam int unsigned TMO     = 1024;

    logic              clk;
    logic              reset_code_rom_n;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              command_complete;
    logic [3:0]        debug_cmd;
    logic [7:0]        code_rom_data_in;
    logic [ADDR_W-1:0] code_rom_addr_in;
    logic              program_rom_mode;
    logic              busy;

    debug_host_link #(
        .ADDR_W         (ADDR_W),
        .MAX_CMD        (MAX_CMD),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk              (clk),
        .reset_code_rom_n (reset_code_rom_n),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .rx_ready         (rx_ready),
        .tx_data          (tx_data),
        .tx_valid         (tx_valid),
        .tx_ready         (tx_ready),
        .command_complete (command_complete),
        .debug_cmd        (debug_cmd),
        .code_rom_data_in (code_rom_data_in),
        .code_rom_addr_in (code_rom_addr_in),
        .program_rom_mode (program_rom_mode),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Observed harness activity
    logic [11:0] wr_a[$];
    logic [7:0]  wr_d[$];
    logic [3:0]  cmd_log[$];
    int          last_wr_cyc = -100;
    int          cmd_cyc = -100;
    int          tx_cyc = -100;

    always @(negedge clk) begin
        if (program_rom_mode) begin
            wr_a.push_back(code_rom_addr_in);
            wr_d.push_back(code_rom_data_in);
            last_wr_cyc = cyc;
        end
        if (debug_cmd != 4'd0) begin
            cmd_log.push_back(debug_cmd);
            cmd_cyc = cyc;
        end
    end

    // Harness model: pulse command_complete comp_delay cycles after an issue (-1 = never)
    int comp_delay = -1;
    initial begin
        command_complete = 1'b0;
        forever begin
            @(negedge clk);
            if (debug_cmd != 4'd0 && comp_delay > 0) begin
                repeat (comp_delay) @(posedge clk);
                #1 command_complete = 1'b1;
                @(posedge clk);
                #1 command_complete = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        while (!rx_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) begin
            fail_now("rx_accept");
            rx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic get_resp(input int hold, output logic [7:0] rsp, output logic rdy_seen);
        int   n = 0;
        logic stable;
        rdy_seen = 1'b0;
        rsp      = 8'h00;
        @(negedge clk);
        while (!tx_valid && n < 3000) begin
            if (rx_ready) rdy_seen = 1'b1;
            @(negedge clk);
            n++;
        end
        if (!tx_valid) begin
            fail_now("tx_wait");
            rx_valid = 1'b0;
            return;
        end
        tx_cyc   = cyc;
        rsp      = tx_data;
        rx_valid = 1'b0;
        if (hold > 0) begin
            stable = 1'b1;
            repeat (hold) begin
                @(negedge clk);
                if (!tx_valid || tx_data !== rsp) stable = 1'b0;
            end
            check("tx_hold_stable", 32'(stable), 32'd1);
            tx_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        check("tx_valid_drop", 32'(tx_valid), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_packet(input logic [7:0] q[$], input int dly, input int hold,
                              output logic [7:0] rsp, output logic rdy);
        wr_a.delete();
        wr_d.delete();
        cmd_log.delete();
        comp_delay  = dly;
        last_wr_cyc = -100;
        cmd_cyc     = -100;
        foreach (q[i]) send_byte(q[i]);
        get_resp(hold, rsp, rdy);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Reference model: expected status of a command packet
    function automatic logic [7:0] cmd_status(input int arg, input int dly);
        if (arg < 1 || arg > int'(MAX_CMD)) return 8'h45;
        if (dly >= 1 && dly <= int'(TMO) - 1) return 8'h4B;
        return 8'h54;
    endfunction

    typedef struct {
        logic [63:0] pkt;
        int          n;
        int          cdly;
        logic [7:0]  rsp;
        int          nwr;
        logic [11:0] a0;
        logic [7:0]  d0;
        logic [11:0] a1;
        logic [7:0]  d1;
        logic [3:0]  cmd;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [7:0] q[$];
        logic [7:0] rsp;
        logic       rdy;
        logic       seen;
        int         bad;

        vecs[0] = '{64'h5000_0403_1122_3300, 7, 0, 8'h4B, 3, 12'h004, 8'h11, 12'h006, 8'h33, 4'd0};
        vecs[1] = '{64'h500F_FF02_AABB_0000, 6, 0, 8'h4B, 2, 12'hFFF, 8'hAA, 12'h000, 8'hBB, 4'd0};
        vecs[2] = '{64'h4302_0000_0000_0000, 2, 3, 8'h4B, 0, 12'h0, 8'h0, 12'h0, 8'h0, 4'd2};
        vecs[3] = '{64'h4300_0000_0000_0000, 2, 3, 8'h45, 0, 12'h0, 8'h0, 12'h0, 8'h0, 4'd0};
        vecs[4] = '{64'h4307_0000_0000_0000, 2, 3, 8'h45, 0, 12'h0, 8'h0, 12'h0, 8'h0, 4'd0};
        vecs[5] = '{64'h9900_0000_0000_0000, 1, 3, 8'h45, 0, 12'h0, 8'h0, 12'h0, 8'h0, 4'd0};
        vecs[6] = '{64'h4303_0000_0000_0000, 2, 1, 8'h4B, 0, 12'h0, 8'h0, 12'h0, 8'h0, 4'd3};
        vecs[7] = '{64'h43F1_0000_0000_0000, 2, 3, 8'h45, 0, 12'h0, 8'h0, 12'h0, 8'h0, 4'd0};
        vecs[8] = '{64'h5012_3401_5A00_0000, 5, 0, 8'h4B, 1, 12'h234, 8'h5A, 12'h234, 8'h5A, 4'd0};

        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b1;
        reset_code_rom_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_debug_cmd", 32'(debug_cmd), 32'd0);
        check("rst_prog_mode", 32'(program_rom_mode), 32'd0);
        check("rst_rom_addr", 32'(code_rom_addr_in), 32'd0);
        check("rst_rom_data", 32'(code_rom_data_in), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rx_ready", 32'(rx_ready), 32'd1);
        @(negedge clk);
        reset_code_rom_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vector table
        for (int v = 0; v < 9; v++) begin
            q.delete();
            for (int i = 0; i < vecs[v].n; i++) q.push_back(vecs[v].pkt[63 - 8 * i -: 8]);
            run_packet(q, vecs[v].cdly, 0, rsp, rdy);
            check($sformatf("v%0d_rsp", v), 32'(rsp), 32'(vecs[v].rsp));
            check($sformatf("v%0d_rx_ready_low", v), 32'(rdy), 32'd0);
            check($sformatf("v%0d_nwr", v), 32'(wr_a.size()), 32'(vecs[v].nwr));
            if (vecs[v].nwr > 0 && wr_a.size() > 0) begin
                check($sformatf("v%0d_a0", v), 32'(wr_a[0]), 32'(vecs[v].a0));
                check($sformatf("v%0d_d0", v), 32'(wr_d[0]), 32'(vecs[v].d0));
                check($sformatf("v%0d_alast", v), 32'(wr_a[$]), 32'(vecs[v].a1));
                check($sformatf("v%0d_dlast", v), 32'(wr_d[$]), 32'(vecs[v].d1));
                check($sformatf("v%0d_k_after_strobe", v), 32'(tx_cyc - last_wr_cyc), 32'd1);
            end
            check($sformatf("v%0d_ncmd", v), 32'(cmd_log.size()),
                  32'((vecs[v].cmd != 4'd0) ? 1 : 0));
            if (vecs[v].cmd != 4'd0 && cmd_log.size() > 0) begin
                check($sformatf("v%0d_cmd", v), 32'(cmd_log[0]), 32'(vecs[v].cmd));
            end
        end

        // Completion three cycles after issue: status appears one cycle later
        q = '{8'h43, 8'h02};
        run_packet(q, 3, 0, rsp, rdy);
        check("cmp3_latency", 32'(tx_cyc - cmd_cyc), 32'd4);

        // No completion: timeout exactly TMO cycles after the issue cycle
        run_packet(q, -1, 0, rsp, rdy);
        check("tmo_rsp", 32'(rsp), 32'h54);
        check("tmo_latency", 32'(tx_cyc - cmd_cyc), 32'(TMO));
        check("tmo_ncmd", 32'(cmd_log.size()), 32'd1);

        // Completion on the final count cycle wins; one cycle later is too late
        run_packet(q, TMO - 1, 0, rsp, rdy);
        check("edge_cmp_rsp", 32'(rsp), 32'h4B);
        check("edge_cmp_latency", 32'(tx_cyc - cmd_cyc), 32'(TMO));
        run_packet(q, TMO, 0, rsp, rdy);
        check("edge_tmo_rsp", 32'(rsp), 32'h54);

        // Source holds a byte while the command is outstanding: must not be taken
        wr_a.delete();
        cmd_log.delete();
        comp_delay = 5;
        send_byte(8'h43);
        send_byte(8'h01);
        rx_data  = 8'h50;
        rx_valid = 1'b1;
        get_resp(0, rsp, rdy);
        check("hold_rx_ready_low", 32'(rdy), 32'd0);
        check("hold_rsp", 32'(rsp), 32'h4B);
        repeat (2) @(posedge clk);
        #1;
        check("hold_idle_after", 32'(busy), 32'd0);

        // Status byte held stable while the host stalls
        tx_ready = 1'b0;
        q = '{8'h43, 8'h09};
        run_packet(q, 0, 10, rsp, rdy);
        check("stall_rsp", 32'(rsp), 32'h45);

        // Reset mid-data after two of four bytes
        send_byte(8'h50);
        send_byte(8'h00);
        send_byte(8'h10);
        send_byte(8'h04);
        send_byte(8'hA1);
        send_byte(8'hB2);
        @(negedge clk);
        check("mid_strobe_live", 32'(program_rom_mode), 32'd1);
        reset_code_rom_n = 1'b0;
        #1;
        check("mid_rst_prog", 32'(program_rom_mode), 32'd0);
        check("mid_rst_addr", 32'(code_rom_addr_in), 32'd0);
        check("mid_rst_data", 32'(code_rom_data_in), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_tx", 32'(tx_valid), 32'd0);
        @(negedge clk);
        reset_code_rom_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (tx_valid) seen = 1'b1;
        end
        check("mid_rst_no_tx", 32'(seen), 32'd0);
        @(posedge clk);
        #1;
        q = '{8'h50, 8'h00, 8'h00, 8'h01, 8'h5A};
        run_packet(q, 0, 0, rsp, rdy);
        check("post_rst_rsp", 32'(rsp), 32'h4B);
        check("post_rst_nwr", 32'(wr_a.size()), 32'd1);
        if (wr_a.size() > 0) begin
            check("post_rst_addr", 32'(wr_a[0]), 32'h000);
            check("post_rst_data", 32'(wr_d[0]), 32'h5A);
        end

        // Count byte 0 means 256 bytes
        q = '{8'h50, 8'h01, 8'h00, 8'h00};
        for (int i = 0; i < 256; i++) q.push_back(8'(i) ^ 8'h3C);
        run_packet(q, 0, 0, rsp, rdy);
        check("len256_rsp", 32'(rsp), 32'h4B);
        check("len256_nwr", 32'(wr_a.size()), 32'd256);
        bad = 0;
        for (int i = 0; i < wr_a.size(); i++) begin
            if (wr_a[i] !== 12'(32'h100 + i) || wr_d[i] !== (8'(i) ^ 8'h3C)) bad++;
        end
        check("len256_content", 32'(bad), 32'd0);

        // Randomized packets against the packet-level model
        for (int t = 0; t < 40; t++) begin
            int          kind;
            int          arg;
            int          dly;
            int          len;
            logic [15:0] a16;
            logic [7:0]  op;
            logic [7:0]  exp_r;
            logic [11:0] ea[$];
            logic [7:0]  ed[$];
            kind = int'($urandom_range(0, 2));
            q.delete();
            ea.delete();
            ed.delete();
            dly = 0;
            arg = 0;
            if (kind == 0) begin
                a16 = 16'($urandom_range(0, 65535));
                len = int'($urandom_range(1, 5));
                q = '{8'h50, a16[15:8], a16[7:0], 8'(len)};
                for (int i = 0; i < len; i++) begin
                    q.push_back(8'($urandom_range(0, 255)));
                    ea.push_back(12'((int'(a16) + i) % (1 << ADDR_W)));
                    ed.push_back(q[$]);
                end
                exp_r = 8'h4B;
            end else if (kind == 1) begin
                arg = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                                  : int'($urandom_range(0, 5));
                dly = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(1, 20));
                q = '{8'h43, 8'(arg)};
                exp_r = cmd_status(arg, dly);
            end else begin
                do op = 8'($urandom_range(0, 255)); while (op == 8'h50 || op == 8'h43);
                q = '{op};
                exp_r = 8'h45;
            end
            run_packet(q, dly, 0, rsp, rdy);
            check($sformatf("rnd%0d_rsp", t), 32'(rsp), 32'(exp_r));
            check($sformatf("rnd%0d_nwr", t), 32'(wr_a.size()), 32'(ea.size()));
            bad = 0;
            for (int i = 0; i < ea.size() && i < wr_a.size(); i++) begin
                if (wr_a[i] !== ea[i] || wr_d[i] !== ed[i]) bad++;
            end
            check($sformatf("rnd%0d_writes", t), 32'(bad), 32'd0);
            if (kind == 1 && arg >= 1 && arg <= int'(MAX_CMD)) begin
                check($sformatf("rnd%0d_ncmd", t), 32'(cmd_log.size()), 32'd1);
                if (cmd_log.size() > 0) begin
                    check($sformatf("rnd%0d_cmd", t), 32'(cmd_log[0]), 32'(arg));
                end
            end else begin
                check($sformatf("rnd%0d_ncmd", t), 32'(cmd_log.size()), 32'd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
